switch_conditioner: RTL and testbench
=====================================

// Module: switch_conditioner
// PURPOSE
//  Input stage between the board slide switches and the game logic. It does three things:
//   - synchronises and debounces all switches;
//   - turns each debounced flip, in either direction, into a one-cycle "whack" strobe;
//   - encodes the strobe as an index for the game/scoring logic.
//  It suppresses spurious whacks at power-up and while the game is disabled.
// PARAMETERS
//  N_SW        16      number of switches
//  TICK_DIV    100000  clk cycles per debounce sample tick (1 kHz at 100 MHz)
//  STABLE_CNT  4       consecutive disagreeing ticks needed to accept a new level (>=1)
// PORTS
//  clk          in   1                    system clock, all state on rising edge
//  reset        in   1                    asynchronous, active-low reset (0 = reset)
//  enable       in   1                    1 = whack strobes allowed (game running)
//  sw_raw       in   N_SW                 raw, asynchronous switch levels
//  sw_clean     out  N_SW                 debounced switch levels
//  toggle       out  N_SW                 one-cycle strobe per bit on a debounced flip
//  whack_valid  out  1                    |toggle
//  whack_idx    out  $clog2(N_SW)         lowest set bit index of toggle; 0 when none set
//  whack_multi  out  1                    more than one toggle bit set this cycle
//  ready        out  1                    1 once the INIT settle phase is complete
// BEHAVIOUR
//  Reset (reset=0, async):
//   - all outputs 0; synchroniser flops, tick counter and per-bit counters cleared;
//   - state=INIT.
//  Sync: 2-FF synchroniser per bit; sync_q = sw_raw delayed 2 clk.
//  Tick:
//   - tick_cnt counts 0..TICK_DIV-1 and wraps to 0;
//   - tick=1 for exactly 1 clk when tick_cnt==TICK_DIV-1.
//  FSM, 2 states:
//   - INIT: counts STABLE_CNT ticks with sw_clean held at 0 and toggle held at 0.
//     On the STABLE_CNT-th tick, sw_clean<=sync_q (no strobes) and state goes to RUN.
//   - RUN: ready=1. Stays in RUN until reset.
//  Debounce per bit i (RUN only, evaluated on tick):
//   - sync_q[i]==sw_clean[i]: cnt[i]<=0.
//   - sync_q[i]!=sw_clean[i] and cnt[i]<STABLE_CNT-1: cnt[i]<=cnt[i]+1.
//   - sync_q[i]!=sw_clean[i] and cnt[i]==STABLE_CNT-1: sw_clean[i]<=~sw_clean[i], cnt[i]<=0.
//   - No change occurs between ticks. cnt width is $clog2(STABLE_CNT+1) and it never wraps.
//  Strobes:
//   - toggle[i]=1 for the single clk after sw_clean[i] flips, but only if enable=1 on that cycle.
//   - With enable=0, sw_clean still tracks and toggle stays 0; no deferred strobe appears when enable rises.
//   - toggle is registered.
//   - whack_valid, whack_idx and whack_multi are registered alongside toggle, so all four are cycle-aligned.
//  Latency: raw edge to toggle = 2 clk sync + STABLE_CNT ticks (phase-dependent) + 1 clk.
//  Bounce: any return to the old level before the count completes clears cnt[i]; no strobe results.
//  Simultaneous flips: all bits strobe in the same cycle, whack_idx = lowest index, whack_multi=1.
//  Reset mid-operation: immediate async clear and re-entry into INIT; no strobe is emitted on release.
// STRUCTURE
//  Shared package holds:
//   - default constants N_SW, TICK_DIV, STABLE_CNT;
//   - 1-bit FSM state encoding (INIT=0, RUN=1).
//  Sub-module debounce_bit contains the sync FFs, counter and clean flop for one bit.
//   - It takes tick, run and enable as inputs.
//   - It is instantiated N_SW times in a generate loop.
//  The top level holds the tick divider, the FSM and the priority encoder for whack_idx/whack_multi.
// TESTING (bench uses TICK_DIV=4, STABLE_CNT=3)
//  1. Release reset with sw_raw=16'h0005 held -> ready=1 after 3 ticks; sw_clean=16'h0005; toggle never nonzero.
//  2. In RUN, sw_raw[3] 0->1 and hold -> one toggle=16'h0008 pulse ~2+12+1 clk later; whack_idx=3, whack_valid=1, whack_multi=0.
//  3. sw_raw[7] toggles every 2 clk for 24 clk, then holds 1 -> no strobe during bounce; exactly one toggle[7] afterwards.
//  4. sw_raw[2] and sw_raw[9] flip in the same clk -> toggle=16'h0204 in one cycle; whack_idx=2, whack_multi=1.
//  5. enable=0, flip sw_raw[5] -> sw_clean[5] follows, toggle=0; raise enable -> still no toggle[5].
//  6. Drive reset=0 while cnt[4]=2 -> all outputs 0 at once; after release, INIT repeats and no strobe for bit 4.

Source files
------------

// File: rtl/switch_conditioner_pkg.sv
// Shared constants and FSM encoding for the slide-switch input stage.
package switch_conditioner_pkg;

  localparam int DEF_N_SW       = 16;
  localparam int DEF_TICK_DIV   = 100000;
  localparam int DEF_STABLE_CNT = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch: 2-FF synchroniser, tick-sampled debounce counter, clean level and strobe flop.
module debounce_bit
  import switch_conditioner_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic run,
  input  logic load,
  input  logic enable,
  input  logic raw,
  output logic sw_clean,
  output logic strobe_next,
  output logic toggle
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          meta_reg;
  logic          sync_reg;
  logic          clean_reg;
  logic          clean_next;
  logic          flip_reg;
  logic          flip_next;
  logic          toggle_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    clean_next = clean_reg;
    cnt_next   = cnt_reg;
    flip_next  = 1'b0;
    // The end-of-settle load adopts the current level silently.
    if (load) begin
      clean_next = sync_reg;
      cnt_next   = '0;
    end else if (run && tick) begin
      if (sync_reg == clean_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_LAST) begin
        clean_next = ~clean_reg;
        cnt_next   = '0;
        flip_next  = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Enable is sampled in the cycle the new clean level is visible.
  assign strobe_next = flip_reg & enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      clean_reg  <= 1'b0;
      cnt_reg    <= '0;
      flip_reg   <= 1'b0;
      toggle_reg <= 1'b0;
    end else begin
      meta_reg   <= raw;
      sync_reg   <= meta_reg;
      clean_reg  <= clean_next;
      cnt_reg    <= cnt_next;
      flip_reg   <= flip_next;
      toggle_reg <= strobe_next;
    end
  end

  assign sw_clean = clean_reg;
  assign toggle   = toggle_reg;

endmodule

// File: rtl/switch_conditioner.sv
// Switch input stage: shared tick divider, INIT/RUN settle FSM, per-bit debouncers
// and a registered priority encoder for the whack strobes.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int N_SW       = DEF_N_SW,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  localparam int IW        = (N_SW > 1) ? $clog2(N_SW) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_SW-1:0] toggle,
  output logic            whack_valid,
  output logic [IW-1:0]   whack_idx,
  output logic            whack_multi,
  output logic            ready
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(STABLE_CNT - 1);

  logic [TW-1:0]   tick_cnt_reg;
  logic            tick;
  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   init_cnt_reg;
  logic [CW-1:0]   init_cnt_next;
  logic            load;
  logic            run;
  logic [N_SW-1:0] strobe_vec;
  logic            valid_next;
  logic            multi_next;
  logic [IW-1:0]   idx_next;
  logic            valid_reg;
  logic            multi_reg;
  logic [IW-1:0]   idx_reg;

  assign tick = (tick_cnt_reg == TICK_LAST);
  assign run  = (state_reg == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    load          = 1'b0;
    case (state_reg)
      ST_INIT: begin
        if (tick) begin
          if (init_cnt_reg == INIT_LAST) begin
            load          = 1'b1;
            init_cnt_next = '0;
            state_next    = ST_RUN;
          end else begin
            init_cnt_next = init_cnt_reg + 1'b1;
          end
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  generate
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
      debounce_bit #(
        .STABLE_CNT(STABLE_CNT)
      ) u_bit (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .run        (run),
        .load       (load),
        .enable     (enable),
        .raw        (sw_raw[gi]),
        .sw_clean   (sw_clean[gi]),
        .strobe_next(strobe_vec[gi]),
        .toggle     (toggle[gi])
      );
    end
  endgenerate

  // Encode from the same pre-register vector as toggle so all four outputs align.
  always_comb begin
    idx_next = '0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (strobe_vec[i]) begin
        idx_next = IW'(i);
      end
    end
  end

  assign valid_next = |strobe_vec;
  assign multi_next = |(strobe_vec & (strobe_vec - 1'b1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      multi_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      multi_reg <= multi_next;
      idx_reg   <= idx_next;
    end
  end

  assign whack_valid = valid_reg;
  assign whack_multi = multi_reg;
  assign whack_idx   = idx_reg;
  assign ready       = run;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with a cycle-level reference model and literal spot checks.
module tb_switch_conditioner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sw_raw = 16'h0000;
  logic [15:0] sw_clean;
  logic [15:0] toggle;
  logic        whack_valid;
  logic [3:0]  whack_idx;
  logic        whack_multi;
  logic        ready;

  int checks = 0;
  int errors = 0;

  switch_conditioner #(
    .N_SW(16),
    .TICK_DIV(4),
    .STABLE_CNT(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .toggle     (toggle),
    .whack_valid(whack_valid),
    .whack_idx  (whack_idx),
    .whack_multi(whack_multi),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  // Reference model: m_k = rising edges since reset release; ticks fall on every 4th edge,
  // the synchronised level at edge k is the raw level sampled two edges earlier.
  int          m_k;
  logic [15:0] m_clean;
  logic [15:0] m_flip;
  logic [15:0] m_tog;
  logic        m_ready;
  int          m_streak[16];
  logic [15:0] raw_q[$];
  logic [15:0] m_sync;
  logic [15:0] m_new_tog;
  int          m_ticks_before;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k = 0;
      m_clean = '0;
      m_flip = '0;
      m_tog = '0;
      m_ready = 1'b0;
      raw_q.delete();
      for (int i = 0; i < 16; i++) m_streak[i] = 0;
    end else begin
      m_k++;
      m_sync = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 16'h0000;
      raw_q.push_back(sw_raw);
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      m_ticks_before = (m_k - 1) / 4;
      m_new_tog = m_flip & {16{enable}};
      m_flip = '0;
      if (m_k % 4 == 0) begin
        if (m_ticks_before == 2) begin
          m_clean = m_sync;
        end else if (m_ticks_before >= 3) begin
          for (int i = 0; i < 16; i++) begin
            if (m_sync[i] != m_clean[i]) begin
              m_streak[i]++;
              if (m_streak[i] == 3) begin
                m_clean[i] = ~m_clean[i];
                m_flip[i] = 1'b1;
                m_streak[i] = 0;
              end
            end else begin
              m_streak[i] = 0;
            end
          end
        end
      end
      m_tog = m_new_tog;
      m_ready = ((m_k / 4) >= 3);
    end
  end

  int pulse_total[16];

  always @(negedge clk) begin
    chk("sw_clean", sw_clean, m_clean);
    chk("toggle", toggle, m_tog);
    chk("whack_valid", whack_valid, |m_tog);
    chk("whack_idx", whack_idx, lowest(m_tog));
    chk("whack_multi", whack_multi, $countones(m_tog) > 1);
    chk("ready", ready, m_ready);
    for (int i = 0; i < 16; i++) pulse_total[i] += int'(toggle[i]);
  end

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
  endtask

  task automatic wait_toggle(output logic [15:0] t, output logic v, output logic [3:0] idx,
                             output logic mu);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (toggle == 16'h0000 && n < 40);
    t = toggle;
    v = whack_valid;
    idx = whack_idx;
    mu = whack_multi;
  endtask

  task automatic align_phase(input int ph);
    int n;
    n = 0;
    while (m_k % 4 != ph && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int base;
    int sum;
    logic [15:0] t;
    logic v;
    logic mu;
    logic [3:0] idx;

    for (int i = 0; i < 16; i++) pulse_total[i] = 0;

    // 1: power-up settle with switches already on
    reset = 1'b0;
    enable = 1'b1;
    sw_raw = 16'h0005;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1'b0);
    reset = 1'b1;
    wait_ready(n);
    chk("init_latency", n, 12);
    chk("init_clean", sw_clean, 16'h0005);
    sum = 0;
    for (int i = 0; i < 16; i++) sum += pulse_total[i];
    chk("init_no_strobe", sum, 0);
    $display("T1 settle: ready after %0d clk, sw_clean=%h", n, sw_clean);

    // 2: single flip of bit 3
    @(negedge clk);
    sw_raw[3] = 1'b1;
    wait_toggle(t, v, idx, mu);
    chk("t2_toggle", t, 16'h0008);
    chk("t2_valid", v, 1'b1);
    chk("t2_idx", idx, 4'd3);
    chk("t2_multi", mu, 1'b0);
    $display("T2 flip bit3: toggle=%h idx=%0d multi=%0b", t, idx, mu);

    // 3: bounce bit 7 in the phase the tick never catches, then settle high
    repeat (4) @(negedge clk);
    align_phase(2);
    base = pulse_total[7];
    for (int r = 0; r < 6; r++) begin
      sw_raw[7] = 1'b1;
      repeat (2) @(negedge clk);
      sw_raw[7] = 1'b0;
      repeat (2) @(negedge clk);
    end
    chk("t3_bounce_pulses", pulse_total[7] - base, 0);
    chk("t3_bounce_clean", sw_clean[7], 1'b0);
    sw_raw[7] = 1'b1;
    repeat (30) @(negedge clk);
    chk("t3_final_pulses", pulse_total[7] - base, 1);
    chk("t3_final_clean", sw_clean[7], 1'b1);
    $display("T3 bounce bit7: pulses=%0d sw_clean[7]=%0b", pulse_total[7] - base, sw_clean[7]);

    // 4: bits 2 and 9 flip together
    @(negedge clk);
    sw_raw = sw_raw ^ 16'h0204;
    wait_toggle(t, v, idx, mu);
    chk("t4_toggle", t, 16'h0204);
    chk("t4_valid", v, 1'b1);
    chk("t4_idx", idx, 4'd2);
    chk("t4_multi", mu, 1'b1);
    $display("T4 dual flip: toggle=%h idx=%0d multi=%0b", t, idx, mu);

    // 5: disabled game still tracks, never strobes, nothing deferred
    repeat (4) @(negedge clk);
    enable = 1'b0;
    base = pulse_total[5];
    sw_raw[5] = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_clean", sw_clean[5], 1'b1);
    chk("t5_no_pulse", pulse_total[5] - base, 0);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_no_deferred", pulse_total[5] - base, 0);
    $display("T5 disabled flip bit5: sw_clean[5]=%0b pulses=%0d", sw_clean[5], pulse_total[5] - base);

    // 6: reset lands with bit 4 two ticks into its count
    align_phase(0);
    base = pulse_total[4];
    sw_raw[4] = 1'b1;
    repeat (9) @(negedge clk);
    chk("t6_pre_clean4", sw_clean[4], 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_clean", sw_clean, 16'h0000);
    chk("t6_rst_toggle", toggle, 16'h0000);
    chk("t6_rst_valid", whack_valid, 1'b0);
    chk("t6_rst_idx", whack_idx, 4'd0);
    chk("t6_rst_multi", whack_multi, 1'b0);
    chk("t6_rst_ready", ready, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_ready(n);
    chk("t6_reinit_latency", n, 12);
    chk("t6_reinit_clean", sw_clean, 16'h02B9);
    repeat (10) @(negedge clk);
    chk("t6_no_pulse4", pulse_total[4] - base, 0);
    $display("T6 mid-count reset: ready after %0d clk, sw_clean=%h, bit4 pulses=%0d",
             n, sw_clean, pulse_total[4] - base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
